// File: rtl/oled_text_sequencer.sv
// oled_text_sequencer: refreshes a ROWS x COLS character page on OLEDCtrl.
// One row (DIGIT_ROW) shows the name of the latest classifier result; the
// other rows come from a host-writable text RAM. Dirty rows trigger a pass of
// character writes followed by one display update.
// Build option: define OLED_SEQ_DIRTY_ROW_EN to rewrite only dirty rows;
// otherwise any dirty event rewrites the whole page.
module oled_text_sequencer #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 16,
  parameter int unsigned DIGIT_W   = 32,
  parameter int unsigned DIGIT_ROW = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DIGIT_W-1:0]              detected_digit,
  input  logic                            digit_valid,
  input  logic                            text_we,
  input  logic [$clog2(ROWS*COLS)-1:0]    text_addr,
  input  logic [7:0]                      text_data,
  input  logic                            disp_on_ready,
  input  logic                            write_ready,
  input  logic                            update_ready,
  output logic                            disp_on_start,
  output logic                            write_start,
  output logic                            update_start,
  output logic                            update_clear,
  output logic [8:0]                      write_base_addr,
  output logic [7:0]                      write_ascii_data,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
`ifdef OLED_SEQ_DIRTY_ROW_EN
  localparam bit ROW_EN = 1'b1;
`else
  localparam bit ROW_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_PWR, S_PWR_WAIT, S_IDLE, S_WR, S_WR_WAIT, S_UPD, S_UPD_WAIT
  } state_t;

  state_t               state;
  logic                 skip;
  logic [RW-1:0]        row;
  logic [CW-1:0]        col;
  logic [ROWS-1:0]      snap_mask;
  logic [DIGIT_W-1:0]   snap_digit;
  logic [DIGIT_W-1:0]   held_digit;
  logic [ROWS-1:0]      dirty;
  logic [ROWS-1:0]      dirty_set;
  logic [7:0]           text_ram [CELLS];

  logic                 take_snap;
  logic [ROWS-1:0]      snap_mask_c;
  int unsigned          first_row_c;
  int unsigned          nxt_row_c;
  logic                 text_hit;
  logic [31:0]          wr_row_c;
  logic [AW-1:0]        rd_idx;
  logic [7:0]           cell_char_c;

  // Lowest set row of m at or above 'from'; ROWS when there is none.
  function automatic int unsigned next_row(input logic [ROWS-1:0] m, input int unsigned from);
    next_row = ROWS;
    for (int unsigned r = ROWS; r > 0; r--) begin
      if ((r - 1) >= from && m[r-1]) next_row = r - 1;
    end
  endfunction

  // Character at column c of the digit name, space padded past the name.
  function automatic logic [7:0] digit_char(input logic [DIGIT_W-1:0] d, input logic [CW-1:0] c);
    logic [63:0] name;
    logic [63:0] sh;
    if (d > DIGIT_W'(9)) name = " None   ";
    else begin
      case (4'(d))
        4'd0:    name = " Zero   ";
        4'd1:    name = " One    ";
        4'd2:    name = " Two    ";
        4'd3:    name = " Three  ";
        4'd4:    name = " Four   ";
        4'd5:    name = " Five   ";
        4'd6:    name = " Six    ";
        4'd7:    name = " Seven  ";
        4'd8:    name = " Eight  ";
        4'd9:    name = " Nine   ";
        default: name = " None   ";
      endcase
    end
    sh = name << {c, 3'b000};
    digit_char = (32'(c) < 32'd8) ? sh[63:56] : 8'h20;
  endfunction

  assign update_clear = 1'b0;

  // Snapshot / cell selection helpers shared by the FSM and dirty tracking.
  always_comb begin
    take_snap   = (state == S_IDLE) && (|dirty);
    snap_mask_c = ROW_EN ? dirty : '1;
    first_row_c = next_row(snap_mask_c, 0);
    nxt_row_c   = next_row(snap_mask, 32'(row) + 32'd1);
    text_hit    = text_we && (32'(text_addr) < CELLS);
    wr_row_c    = 32'(text_addr) / COLS;
    rd_idx      = AW'(32'(row) * COLS + 32'(col));
    cell_char_c = (32'(row) == DIGIT_ROW) ? digit_char(snap_digit, col) : text_ram[rd_idx];
  end

  // New dirty events this cycle: changed digit, or text write to a shown row.
  always_comb begin
    dirty_set = '0;
    if (digit_valid && (detected_digit != held_digit)) dirty_set[DIGIT_ROW] = 1'b1;
    if (text_hit) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (r != DIGIT_ROW && r == wr_row_c) dirty_set[r] = 1'b1;
      end
    end
  end

  // Held digit and dirty mask; events coinciding with a snapshot survive it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_digit <= '1;
      dirty      <= '1;
    end else begin
      if (digit_valid) held_digit <= detected_digit;
      dirty <= (take_snap ? (dirty & ~snap_mask_c) : dirty) | dirty_set;
    end
  end

  // Host text RAM, cleared to spaces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CELLS; i++) text_ram[i] <= 8'h20;
    end else if (text_hit) begin
      text_ram[text_addr] <= text_data;
    end
  end

  // Refresh sequencer: power-on, per-cell writes, then one display update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_PWR;
      skip             <= 1'b0;
      row              <= '0;
      col              <= '0;
      snap_mask        <= '0;
      snap_digit       <= '1;
      disp_on_start    <= 1'b0;
      write_start      <= 1'b0;
      update_start     <= 1'b0;
      write_base_addr  <= '0;
      write_ascii_data <= '0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      disp_on_start <= 1'b0;
      write_start   <= 1'b0;
      update_start  <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        S_PWR: begin
          if (disp_on_ready) begin
            disp_on_start <= 1'b1;
            skip          <= 1'b1;
            state         <= S_PWR_WAIT;
          end
        end
        S_PWR_WAIT: begin
          if (skip) skip <= 1'b0;
          else if (disp_on_ready) state <= S_IDLE;
        end
        S_IDLE: begin
          if (take_snap) begin
            snap_mask  <= snap_mask_c;
            snap_digit <= held_digit;
            row        <= RW'(first_row_c);
            col        <= '0;
            state      <= S_WR;
          end
        end
        S_WR: begin
          if (write_ready) begin
            write_start      <= 1'b1;
            busy             <= 1'b1;
            write_base_addr  <= {2'(row), 4'(col), 3'b000};
            write_ascii_data <= cell_char_c;
            skip             <= 1'b1;
            state            <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (skip) skip <= 1'b0;
          else if (write_ready) begin
            if (col == CW'(COLS - 1)) begin
              if (nxt_row_c >= ROWS) state <= S_UPD;
              else begin
                row   <= RW'(nxt_row_c);
                col   <= '0;
                state <= S_WR;
              end
            end else begin
              col   <= col + 1'b1;
              state <= S_WR;
            end
          end
        end
        S_UPD: begin
          if (update_ready) begin
            update_start <= 1'b1;
            skip         <= 1'b1;
            state        <= S_UPD_WAIT;
          end
        end
        S_UPD_WAIT: begin
          if (skip) skip <= 1'b0;
          else if (update_ready) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_PWR;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_text_sequencer.sv
// Testbench for oled_text_sequencer (ROWS=4, COLS=16, DIGIT_ROW=2).
module tb_oled_text_sequencer;

  localparam int ROWS      = 4;
  localparam int COLS      = 16;
  localparam int DIGIT_ROW = 2;
  localparam int CELLS     = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] detected_digit;
  logic        digit_valid, text_we;
  logic [5:0]  text_addr;
  logic [7:0]  text_data;
  logic        disp_on_ready, write_ready, update_ready;
  logic        disp_on_start, write_start, update_start, update_clear;
  logic [8:0]  write_base_addr;
  logic [7:0]  write_ascii_data;
  logic        busy, frame_done;

  oled_text_sequencer #(.ROWS(4), .COLS(16), .DIGIT_W(32), .DIGIT_ROW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .detected_digit(detected_digit), .digit_valid(digit_valid),
    .text_we(text_we), .text_addr(text_addr), .text_data(text_data),
    .disp_on_ready(disp_on_ready), .write_ready(write_ready), .update_ready(update_ready),
    .disp_on_start(disp_on_start), .write_start(write_start), .update_start(update_start),
    .update_clear(update_clear), .write_base_addr(write_base_addr),
    .write_ascii_data(write_ascii_data), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] w_addr [$];
  logic [7:0] w_data [$];
  int disp_cnt = 0, upd_cnt = 0, fd_cnt = 0;
  bit busy_seen = 1'b0;
  logic [7:0] tb_ram [CELLS];
  logic [7:0] img1 [CELLS];

  typedef struct {
    logic [31:0] digit;
    bit          change;
    string       name;
  } vec_t;
  localparam int NV = 7;
  vec_t vecs [NV];

  // Event monitor, sampled 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (write_start) begin
        w_addr.push_back(write_base_addr);
        w_data.push_back(write_ascii_data);
        checks++;
        if (!busy) begin
          errors++;
          $display("FAIL busy_at_write busy=%0b required=1", busy);
        end
      end
      if (disp_on_start) disp_cnt++;
      if (update_start) upd_cnt++;
      if (frame_done) begin
        fd_cnt++;
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL busy_at_frame_done busy=%0b required=0", busy);
        end
      end
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_mask(input logic [3:0] m);
`ifdef OLED_SEQ_DIRTY_ROW_EN
    return m;
`else
    return m | 4'hF;
`endif
  endfunction

  // Compare captured writes with the expected cell sequence for the given rows.
  task automatic check_pass(input logic [3:0] rmask, input string dname,
                            input logic [7:0] img [CELLS], input string tag);
    int n = 0;
    int bad = 0;
    int first = -1;
    logic [8:0] ea, fa_e, fa_a;
    logic [7:0] ed, fd_e, fd_a;
    fa_e = '0; fa_a = '0; fd_e = '0; fd_a = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rmask[r]) begin
        for (int c = 0; c < COLS; c++) begin
          ea = 9'(r * 128 + c * 8);
          if (r == DIGIT_ROW) ed = (c < dname.len()) ? dname[c] : 8'h20;
          else ed = img[r * COLS + c];
          if (n < w_addr.size()) begin
            if (w_addr[n] !== ea || w_data[n] !== ed) begin
              if (first < 0) begin
                first = n; fa_e = ea; fd_e = ed; fa_a = w_addr[n]; fd_a = w_data[n];
              end
              bad++;
            end
          end
          n++;
        end
      end
    end
    checks++;
    if (w_addr.size() != n) begin
      errors++;
      $display("FAIL %s_count writes=%0d required=%0d", tag, w_addr.size(), n);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_data write#%0d addr=0x%0h data=0x%0h required addr=0x%0h data=0x%0h (%0d bad)",
               tag, first, fa_a, fd_a, fa_e, fd_e, bad);
    end
  endtask

  task automatic wait_frame(input int budget, input string tag);
    int start = fd_cnt;
    int k = 0;
    while (fd_cnt == start && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (fd_cnt == start) begin
      errors++;
      $display("FAIL %s_frame_done none after %0d cycles, required one pulse", tag, budget);
    end
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k = 0;
    while (w_addr.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (w_addr.size() < n) begin
      errors++;
      $display("FAIL %s_writes got=%0d required=%0d", tag, w_addr.size(), n);
    end
  endtask

  task automatic clear_capture();
    w_addr.delete();
    w_data.delete();
    busy_seen = 1'b0;
  endtask

  task automatic pulse_text(input logic [5:0] a, input logic [7:0] d);
    text_addr = a; text_data = d; text_we = 1'b1;
    @(negedge clk);
    text_we = 1'b0;
  endtask

  initial begin
    int lat;
    vecs[0] = '{32'd7,  1'b1, " Seven"};
    vecs[1] = '{32'd7,  1'b0, " Seven"};
    vecs[2] = '{32'd12, 1'b1, " None"};
    vecs[3] = '{32'd0,  1'b1, " Zero"};
    vecs[4] = '{32'd3,  1'b1, " Three"};
    vecs[5] = '{32'd3,  1'b0, " Three"};
    vecs[6] = '{32'd9,  1'b1, " Nine"};

    detected_digit = '0; digit_valid = 1'b0;
    text_we = 1'b0; text_addr = '0; text_data = '0;
    disp_on_ready = 1'b1; write_ready = 1'b1; update_ready = 1'b1;
    for (int i = 0; i < CELLS; i++) tb_ram[i] = 8'h20;

    // Power-up
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({disp_on_start, write_start, update_start, update_clear,
                              write_base_addr, write_ascii_data, busy, frame_done}), 32'd0);
    rst_n = 1'b1;
    wait_frame(600, "powerup");
    chk("powerup_disp_on", disp_cnt, 1);
    chk("powerup_update", upd_cnt, 1);
    check_pass(4'hF, " None", tb_ram, "powerup");

    // Digit table
    for (int i = 0; i < NV; i++) begin
      clear_capture();
      detected_digit = vecs[i].digit;
      digit_valid = 1'b1;
      @(negedge clk);
      digit_valid = 1'b0;
      if (vecs[i].change) begin
        lat = 1;
        while (w_addr.size() == 0 && lat < 50) begin
          @(negedge clk);
          lat++;
        end
        chk($sformatf("vec%0d_latency", i), lat, 3);
        wait_frame(600, $sformatf("vec%0d", i));
        check_pass(exp_mask(4'b0100), vecs[i].name, tb_ram, $sformatf("vec%0d", i));
      end else begin
        repeat (20) @(negedge clk);
        chk($sformatf("vec%0d_nochange_writes", i), w_addr.size(), 0);
        chk($sformatf("vec%0d_nochange_busy", i), 32'(busy_seen), 0);
      end
    end

    // Out-of-range digit with write_ready stalled after the 3rd write
    clear_capture();
    detected_digit = 32'd12; digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
    wait_writes(3, 100, "stall");
    write_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("stall_no_write", w_addr.size(), 3);
    write_ready = 1'b1;
    wait_frame(600, "stall");
    check_pass(exp_mask(4'b0100), " None", tb_ram, "stall");

    // Text written into the digit row is stored but never shown
    clear_capture();
    pulse_text(6'd35, 8'h51);
    tb_ram[35] = 8'h51;
    repeat (20) @(negedge clk);
    chk("digit_row_text_writes", w_addr.size(), 0);
    chk("digit_row_text_busy", 32'(busy_seen), 0);

    // Text write during a pass is served by the following pass
    clear_capture();
    detected_digit = 32'd4; digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
    wait_writes(8, 100, "midpass");
    img1 = tb_ram;
    pulse_text(6'd5, 8'h41);
    tb_ram[5] = 8'h41;
    wait_frame(600, "midpass1");
    check_pass(exp_mask(4'b0100), " Four", img1, "midpass1");
    clear_capture();
    wait_frame(600, "midpass2");
    check_pass(exp_mask(4'b0001), " Four", tb_ram, "midpass2");
    chk("midpass2_cell5", (w_addr.size() > 5) ? 32'({w_addr[5], w_data[5]}) : 32'd0,
        32'({9'h028, 8'h41}));

    // Reset in the middle of a pass
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < CELLS; i++) tb_ram[i] = 8'h20;
    clear_capture();
    rst_n = 1'b1;
    wait_writes(30, 600, "rst_mid");
    chk("rst_mid_ws_before", 32'(write_start), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({disp_on_start, write_start, update_start, update_clear,
                                write_base_addr, write_ascii_data, busy, frame_done}), 32'd0);
    @(negedge clk);
    clear_capture();
    disp_cnt = 0; upd_cnt = 0;
    rst_n = 1'b1;
    wait_frame(600, "repowerup");
    chk("repowerup_disp_on", disp_cnt, 1);
    chk("repowerup_update", upd_cnt, 1);
    check_pass(4'hF, " None", tb_ram, "repowerup");

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
